// File: rtl/sampler_pkg.sv
// Shared constants, state encoding and lane-seed derivation for the
// sample retry controller and its xorshift lanes.
package sampler_pkg;

    localparam logic [63:0] XS_MUL       = 64'hD1B5_4A32_D192_ED03;
    localparam logic [63:0] DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;

    localparam int XS_SH_A = 13;
    localparam int XS_SH_B = 7;
    localparam int XS_SH_C = 17;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    // A zero lane would lock xorshift at zero forever, so it is forced to 1.
    function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int unsigned k);
        logic [63:0] s;
        s = seed ^ (64'(k) * XS_MUL);
        if (s == 64'd0) begin
            s = 64'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/sample_retry_controller_if.sv
// Request/result/checker signal bundle; the controller is the slave side,
// the stimulus consumer plus checker form the master side.
interface sample_retry_controller_if
    import sampler_pkg::*;
#(
    parameter int VEC_W = 320,
    parameter int CNT_W = 11
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload is stable while valid.
    logic [63:0]      seed_i;
    logic             seed_we;
    logic             start_valid;
    logic             start_ready;
    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic             sample_valid;
    logic             sample_ready;
    logic [VEC_W-1:0] sample_data;
    logic [CNT_W-1:0] sample_tries;
    logic             sample_fail;
    logic             busy;
    state_t           dbg_state;

    modport slave (
        input  seed_i, seed_we, start_valid, sat_i, sample_ready,
        output start_ready, cand_o, sample_valid, sample_data, sample_tries,
               sample_fail, busy, dbg_state
    );

    modport master (
        output seed_i, seed_we, start_valid, sat_i, sample_ready,
        input  start_ready, cand_o, sample_valid, sample_data, sample_tries,
               sample_fail, busy, dbg_state
    );

endinterface

// File: rtl/xorshift64_step.sv
// One combinational xorshift64 step; the controller instantiates one per lane.
module xorshift64_step
    import sampler_pkg::*;
(
    input  logic [63:0] i_x,
    output logic [63:0] o_y
);

    logic [63:0] w_a;
    logic [63:0] w_b;

    assign w_a = i_x ^ (i_x << XS_SH_A);
    assign w_b = w_a ^ (w_a >> XS_SH_B);
    assign o_y = w_b ^ (w_b << XS_SH_C);

endmodule

// File: rtl/sample_retry_controller.sv
// Drives pseudo-random candidates into an external combinational checker,
// one per cycle, until satisfied or the retry budget is spent.
module sample_retry_controller
    import sampler_pkg::*;
#(
    parameter int          VEC_W     = 320,
    parameter int          MAX_TRIES = 1024,
    parameter logic [63:0] SEED      = DEFAULT_SEED,
    parameter int          CNT_W     = $clog2(MAX_TRIES + 1)
) (
    input logic                      clk,
    input logic                      rst,
    sample_retry_controller_if.slave bus
);

    localparam int               NL      = VEC_W / 64;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

    state_t           r_state;
    logic [63:0]      r_lane [NL];
    logic [CNT_W-1:0] r_tries;
    logic             r_fail;

    logic [63:0]      w_next [NL];
    logic [VEC_W-1:0] w_cand;
    logic [CNT_W-1:0] w_tries_next;

    for (genvar k = 0; k < NL; k++) begin : g_lane
        xorshift64_step u_step (
            .i_x (r_lane[k]),
            .o_y (w_next[k])
        );
        assign w_cand[64*k +: 64] = r_lane[k];
    end

    assign w_tries_next = r_tries + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tries <= '0;
            r_fail  <= 1'b0;
            for (int k = 0; k < NL; k++) begin
                r_lane[k] <= lane_seed(SEED, k);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // Reseed wins over a start request in the same cycle.
                    if (bus.seed_we) begin
                        for (int k = 0; k < NL; k++) begin
                            r_lane[k] <= lane_seed(bus.seed_i, k);
                        end
                    end else if (bus.start_valid) begin
                        for (int k = 0; k < NL; k++) begin
                            r_lane[k] <= w_next[k];
                        end
                        r_tries <= '0;
                        r_fail  <= 1'b0;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.sat_i) begin
                        r_tries <= w_tries_next;
                        r_fail  <= 1'b0;
                        r_state <= DONE;
                    end else if (w_tries_next == MAX_CNT) begin
                        // Last candidate stays on cand_o and is reported.
                        r_tries <= MAX_CNT;
                        r_fail  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_tries <= w_tries_next;
                        for (int k = 0; k < NL; k++) begin
                            r_lane[k] <= w_next[k];
                        end
                    end
                end
                DONE: begin
                    if (bus.sample_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cand_o       = w_cand;
    assign bus.sample_data  = w_cand;
    assign bus.sample_tries = r_tries;
    assign bus.sample_fail  = r_fail;
    assign bus.sample_valid = (r_state == DONE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.start_ready  = (r_state == IDLE) && !bus.seed_we;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_sample_retry_controller.sv
// Scoreboard bench: requests push the model's expected result, a monitor
// pops and compares whenever the controller presents a result.
module tb_sample_retry_controller;

  localparam int          VEC_W     = 320;
  localparam int          MAX_TRIES = 4;
  localparam int          CNT_W     = 3;
  localparam int          NL        = VEC_W / 64;
  localparam logic [63:0] TB_SEED   = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [63:0] TB_MUL    = 64'hD1B5_4A32_D192_ED03;

  typedef logic [VEC_W-1:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_retry_controller_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) bus ();

  sample_retry_controller #(
    .VEC_W     (VEC_W),
    .MAX_TRIES (MAX_TRIES),
    .SEED      (TB_SEED),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checker stub ----------------
  int         sat_mode = 0;
  vec_t       sat_target = '0;
  logic [5:0] sat_thr = 6'd0;

  assign bus.sat_i = (sat_mode == 0) ? 1'b1 :
                     (sat_mode == 1) ? 1'b0 :
                     (sat_mode == 2) ? (bus.cand_o == sat_target) :
                                       (bus.cand_o[5:0] < sat_thr);

  // ---------------- reference model ----------------
  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic vec_t seed_vec(input logic [63:0] s);
    vec_t        v;
    logic [63:0] l;
    for (int k = 0; k < NL; k++) begin
      l = s ^ (64'(k) * TB_MUL);
      if (l == 64'd0) l = 64'd1;
      v[64*k +: 64] = l;
    end
    return v;
  endfunction

  function automatic vec_t step_vec(input vec_t v);
    vec_t r;
    for (int k = 0; k < NL; k++) r[64*k +: 64] = xs(v[64*k +: 64]);
    return r;
  endfunction

  function automatic logic model_sat(input vec_t v);
    case (sat_mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return v == sat_target;
      default: return v[5:0] < sat_thr;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  vec_t             m_vec;
  vec_t             exp_data_q[$];
  logic [CNT_W-1:0] exp_tries_q[$];
  logic             exp_fail_q[$];
  int               exp_acc_q[$];
  vec_t             got_q[$];
  int               n_tests = 0;
  int               n_fail = 0;
  logic             prev_valid = 1'b0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          if (!prev_valid) check("latency", cyc - exp_acc_q[0], exp_tries_q[0] + 1);
          check("sample_data", bus.sample_data, exp_data_q[0]);
          check("sample_tries", bus.sample_tries, exp_tries_q[0]);
          check("sample_fail", bus.sample_fail, exp_fail_q[0]);
          check("start_ready_in_done", bus.start_ready, 0);
          if (bus.sample_ready) begin
            got_q.push_back(exp_data_q[0]);
            void'(exp_data_q.pop_front());
            void'(exp_tries_q.pop_front());
            void'(exp_fail_q.pop_front());
            void'(exp_acc_q.pop_front());
          end
        end
      end
      prev_valid <= bus.sample_valid;
    end
  end

  // ---------------- drivers ----------------
  // All driver tasks start and end just after a rising edge (or at a falling
  // edge for request), so inputs never change near the active edge.
  task automatic do_reset();
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.seed_we = 1'b0;
    bus.sample_ready = 1'b0;
    exp_data_q.delete();
    exp_tries_q.delete();
    exp_fail_q.delete();
    exp_acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_vec = seed_vec(TB_SEED);
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_sample_valid", bus.sample_valid, 0);
    check("rst_sample_tries", bus.sample_tries, 0);
    check("rst_sample_fail", bus.sample_fail, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cand", bus.cand_o, seed_vec(TB_SEED));
  endtask

  task automatic request(output int wait_n);
    vec_t first;
    vec_t v;
    int   t;
    bit   got;
    got = 0;
    wait_n = 0;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.start_ready) begin
        got = 1;
        wait_n = i;
      end
    end
    if (!got) begin
      check("start_accept_timeout", 0, 1);
      bus.start_valid = 1'b0;
      return;
    end
    first = step_vec(m_vec);
    v = first;
    t = 1;
    while (!model_sat(v) && t < MAX_TRIES) begin
      v = step_vec(v);
      t++;
    end
    exp_data_q.push_back(v);
    exp_tries_q.push_back(CNT_W'(t));
    exp_fail_q.push_back(!model_sat(v));
    exp_acc_q.push_back(cyc);
    m_vec = v;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(negedge clk);
    check("first_cand", bus.cand_o, first);
    check("busy_after_accept", bus.busy, 1);
  endtask

  task automatic wait_result(input int hold);
    bit got;
    got = 0;
    for (int i = 0; i < MAX_TRIES + 10 && !got; i++) begin
      @(negedge clk);
      if (bus.sample_valid) got = 1;
    end
    if (!got) begin
      check("valid_timeout", 0, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    bus.sample_ready = 1'b1;
    @(posedge clk); #1;
    bus.sample_ready = 1'b0;
    check("ack_valid_low", bus.sample_valid, 0);
    check("ack_idle", bus.busy, 0);
    check("ack_start_ready", bus.start_ready, 1);
  endtask

  task automatic reseed_only(input logic [63:0] s);
    bus.seed_i = s;
    bus.seed_we = 1'b1;
    @(posedge clk); #1;
    bus.seed_we = 1'b0;
    m_vec = seed_vec(s);
    check("reseed_lanes", bus.cand_o, m_vec);
  endtask

  task automatic reseed_start(input logic [63:0] s);
    int w;
    bus.seed_i = s;
    bus.seed_we = 1'b1;
    bus.start_valid = 1'b1;
    @(negedge clk);
    check("seed_blocks_start", bus.start_ready, 0);
    @(posedge clk); #1;
    bus.seed_we = 1'b0;
    m_vec = seed_vec(s);
    check("seed_start_lanes", bus.cand_o, m_vec);
    check("seed_start_idle", bus.busy, 0);
    request(w);
    check("accept_after_seed", w, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  vec_t seq_a[$];

  initial begin
    int w;
    bus.seed_i = 64'd0;
    bus.seed_we = 1'b0;
    bus.start_valid = 1'b0;
    bus.sample_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Checker always satisfied: one try, result two cycles after accept.
    sat_mode = 0;
    request(w);
    wait_result(0);

    // Checker never satisfied: budget exhausted, last candidate reported.
    do_reset();
    sat_mode = 1;
    request(w);
    wait_result(0);

    // Satisfied on the third candidate, with 5 cycles of backpressure.
    do_reset();
    sat_target = step_vec(step_vec(step_vec(m_vec)));
    sat_mode = 2;
    request(w);
    wait_result(5);
    sat_mode = 0;
    request(w);
    wait_result(0);

    // Reseed priority and reproducibility of the sequence after a reseed.
    sat_mode = 3;
    sat_thr = 6'd20;
    got_q.delete();
    reseed_start(64'h1234);
    wait_result(0);
    request(w);
    wait_result(1);
    seq_a = got_q;
    got_q.delete();
    reseed_start(64'h1234);
    wait_result(0);
    request(w);
    wait_result(2);
    check("reseed_seq_len", got_q.size(), seq_a.size());
    for (int i = 0; i < seq_a.size() && i < got_q.size(); i++) begin
      check("reseed_seq_repeat", got_q[i], seq_a[i]);
    end

    // Reset while checking on the second try.
    sat_mode = 1;
    request(w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("tries_before_rst", bus.sample_tries, 2);
    do_reset();
    sat_mode = 0;
    request(w);
    wait_result(0);

    // Randomized requests, modes, reseeds and backpressure.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) reseed_only({$urandom(), $urandom()});
      sat_mode = $urandom_range(0, 3);
      sat_thr = 6'($urandom_range(0, 63));
      begin
        vec_t t;
        int   k;
        k = $urandom_range(1, MAX_TRIES + 1);
        t = m_vec;
        for (int j = 0; j < k; j++) t = step_vec(t);
        sat_target = t;
      end
      request(w);
      wait_result($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_data_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sample_retry_controller.md
# sample_retry_controller

Sequencing controller for a generated combinational constraint checker (many packed random variables in, single satisfied bit `x` out). On each sample request it drives pseudo-random candidate vectors into the checker, one per cycle, until the checker reports satisfied or a retry budget runs out. It then returns the candidate, the attempt count and a fail flag over a valid/ready handshake. It sits between the stimulus consumer and one checker instance; the checker stays purely combinational and external.

## Interface
- `VEC_W`, 320: candidate width in bits, multiple of 64; the checker's concatenated input vector.
- `MAX_TRIES`, 1024: retry budget per request, ≥1.
- `SEED`, 64'h9E37_79B9_7F4A_7C15: reset seed for all lanes.
- `CNT_W`, $clog2(MAX_TRIES+1): attempt counter width (derived).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_i`  in  64  reseed value.
- `seed_we`  in  1  reseed strobe; honoured in IDLE only.
- `start_valid`  in  1  sample request.
- `start_ready`  out  1  request accepted when both are high.
- `cand_o`  out  VEC_W  registered candidate to checker.
- `sat_i`  in  1  checker result for current `cand_o` (combinational, same cycle).
- `sample_valid`  out  1  result available.
- `sample_ready`  in  1  consumer accepts result.
- `sample_data`  out  VEC_W  accepted candidate (equals `cand_o` while valid).
- `sample_tries`  out  CNT_W  candidates checked for this request.
- `sample_fail`  out  1  budget exhausted without satisfaction.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Candidate = VEC_W/64 lanes; lane k = xorshift64 state (x^=x<<13; x^=x>>7; x^=x<<17). Lane k seed = seed ^ (k × 64'hD1B5_4A32_D192_ED03); a zero lane seed is replaced by 64'h1.
- States: IDLE, CHECK, DONE.
- IDLE: `start_ready` = !`seed_w e`. `seed_we` loads all lanes from `seed_i`, and has priority over start (no accept that cycle). On accept: step all lanes once into `cand_o`, tries ← 0, go CHECK.
- CHECK, each cycle: tries_next = tries+1. If `sat_i`: tries ← tries_next, fail ← 0, go DONE, `cand_o` held. Else if tries_next == MAX_TRIES: tries ← MAX_TRIES, fail ← 1, go DONE, `cand_o` held (last candidate reported). Else: tries ← tries_next, step lanes, stay CHECK.
- DONE: `sample_valid` = 1; data, tries and fail stable until `sample_ready`; then go IDLE. Lanes are not stepped, so the next request starts from step(last).
- `seed_we` outside IDLE is ignored. `start_valid` outside IDLE is not accepted.
- Counter never exceeds MAX_TRIES; no wrap.

## Timing
- Reset values: state IDLE, `start_ready` 1, `sample_valid` 0, `sample_tries` 0, `sample_fail` 0, `busy` 0, `cand_o` = lane seeds from SEED.
- Start accepted at edge N → first candidate on `cand_o` in cycle N+1; if satisfied, `sample_valid` in cycle N+2. General latency: tries+1 cycles from accept to valid.
- One candidate per cycle in CHECK; checker combinational depth sits on the `cand_o`→`sat_i`→state path within one cycle.
- The `sample_valid`&`sample_ready` edge returns to IDLE; the next start can be accepted one cycle later (no same-cycle bypass).
- `rst` in any state: next cycle all reset values apply and lanes reload from SEED; any in-flight result is discarded.

## Structure
- Shared package `sampler_pkg`: `XS_MUL` lane-seed constant, default SEED, xorshift shift amounts (13, 7, 17), state enum `{IDLE, CHECK, DONE}`.
- Sub-module `xorshift64_step`: combinational 64-bit next-state function, instantiated VEC_W/64 times. The controller holds all lane registers.

## Test plan
- Checker stub `sat_i`=1, SEED default: start at cycle 0 → `sample_valid` at cycle 2, tries=1, fail=0, data = step(seed lanes) per the software model.
- Stub `sat_i`=0, MAX_TRIES=4 → valid after 4 CHECK cycles, tries=4, fail=1, data = step⁴(seed lanes).
- Stub satisfied only when `cand_o` == step³(seed lanes) → tries=3, fail=0, data matches the model; the next request's first candidate = step⁴.
- Backpressure: `sample_ready`=0 for 5 cycles in DONE → data, tries and fail stable, `start_ready`=0; ready=1 → IDLE next cycle.
- `seed_we`=1 with `start_valid`=1 in IDLE, `seed_i`=64'h1234 → no accept that cycle, lanes loaded; accept next cycle. Reseeding with the same value twice yields identical sample sequences.
- `rst` pulsed during CHECK at try 2 → IDLE next cycle, `sample_valid` 0, tries 0, `cand_o` = SEED lanes; the following request behaves as after power-on.
